// File: rtl/seq_argmax.sv
// Sequential argmax over C class sums: one candidate compared per clock, lowest index wins ties.
// Optional winning-score output enabled by defining SEQ_ARGMAX_SCORE_EN.
module seq_argmax #(
  parameter int M = 4,
  parameter int C = 4,
  localparam int SumL = $clog2(M + 1),
  localparam int IdxL = (C > 1) ? $clog2(C) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SumL*C-1:0]   sums,
  output logic                busy,
  output logic                valid,
`ifdef SEQ_ARGMAX_SCORE_EN
  output logic [SumL-1:0]     score,
`endif
  output logic [IdxL-1:0]     class_id
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state_q, state_d;
  logic [SumL*C-1:0]   sums_q, sums_d;
  logic [SumL-1:0]     best_q, best_d;
  logic [IdxL-1:0]     best_idx_q, best_idx_d;
  logic [IdxL-1:0]     k_q, k_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [IdxL-1:0]     class_id_q, class_id_d;
`ifdef SEQ_ARGMAX_SCORE_EN
  logic [SumL-1:0]     score_q, score_d;
`endif

  logic [SumL-1:0]     sum_arr [C];
  logic [SumL-1:0]     cur_sum;

  for (genvar gi = 0; gi < C; gi++) begin : g_unpack
    assign sum_arr[gi] = sums_q[gi*SumL +: SumL];
  end

  // Mux on equality so the scan index can never select past C-1.
  always_comb begin
    cur_sum = sum_arr[0];
    for (int i = 1; i < C; i++) begin
      if (k_q == IdxL'(i)) cur_sum = sum_arr[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    sums_d     = sums_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    k_d        = k_q;
    valid_d    = 1'b0;
    class_id_d = class_id_q;
`ifdef SEQ_ARGMAX_SCORE_EN
    score_d    = score_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sums_d     = sums;
          best_d     = sums[SumL-1:0];
          best_idx_d = '0;
          k_d        = IdxL'(1);
          if (C == 1) begin
            state_d    = DONE;
            valid_d    = 1'b1;
            class_id_d = '0;
`ifdef SEQ_ARGMAX_SCORE_EN
            score_d    = sums[SumL-1:0];
`endif
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // Strict compare keeps the earlier (lower) index on ties.
        if (cur_sum > best_q) begin
          best_d     = cur_sum;
          best_idx_d = k_q;
        end
        if (k_q == IdxL'(C - 1)) begin
          state_d    = DONE;
          valid_d    = 1'b1;
          class_id_d = best_idx_d;
`ifdef SEQ_ARGMAX_SCORE_EN
          score_d    = best_d;
`endif
        end else begin
          k_d = k_q + IdxL'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sums_q     <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      k_q        <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      class_id_q <= '0;
`ifdef SEQ_ARGMAX_SCORE_EN
      score_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sums_q     <= sums_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      k_q        <= k_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      class_id_q <= class_id_d;
`ifdef SEQ_ARGMAX_SCORE_EN
      score_q    <= score_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign class_id = class_id_q;
`ifdef SEQ_ARGMAX_SCORE_EN
  assign score    = score_q;
`endif

endmodule
